// File: rtl/ram2_pkg.sv
// Shared widths, depth and FSM encoding for the ram2 master.
// RAM2_MASTER_CLEAR_EN adds the CLEAR state used by the zero-fill sequencer.
package ram2_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int RAM_DEPTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
`ifdef RAM2_MASTER_CLEAR_EN
        ST_CLEAR,
`endif
        ST_TURN
    } state_e;
endpackage

// File: rtl/ram2_master_if.sv
// Client request/response and RAM control bundle; the tri-state data bus stays
// a plain inout on the master so it can be resolved at the RAM's level.
import ram2_pkg::*;

interface ram2_master_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_ena;
    logic              mem_wena;
    logic [ADDR_W-1:0] mem_addr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, mem_ena, mem_wena, mem_addr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_ena, mem_wena, mem_addr
    );
endinterface

// File: rtl/ram2_bus_drv.sv
// Tri-state driver for the shared RAM data bus: drives dout while oe, always
// returns the resolved bus value on din.
module ram2_bus_drv #(
    parameter int W = 32
) (
    input  logic         oe,
    input  logic [W-1:0] dout,
    inout  wire  [W-1:0] bus,
    output logic [W-1:0] din
);
    assign bus = oe ? dout : {W{1'bz}};
    assign din = bus;
endmodule

// File: rtl/ram2_master.sv
// Single-port RAM master over a shared tri-state data bus, with a turnaround
// cycle after every read. RAM2_MASTER_CLEAR_EN adds a zero-fill sequencer.
module ram2_master
    import ram2_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RAM2_MASTER_CLEAR_EN
    input  logic              clear_start,
    output logic              clear_busy,
`endif
    ram2_master_if.master     bus_if,
    inout  wire  [DATA_W-1:0] mem_data_io
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] bus_dout, bus_din;
    logic              clr_go;
`ifdef RAM2_MASTER_CLEAR_EN
    logic              init_q, init_d;

    // A pending post-reset fill or a clear request pre-empts client traffic.
    assign clr_go = init_q | clear_start;
`else
    assign clr_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rsp_vld_q <= 1'b0;
`ifdef RAM2_MASTER_CLEAR_EN
            init_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rsp_vld_q <= rsp_vld_d;
`ifdef RAM2_MASTER_CLEAR_EN
            init_q    <= init_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        rsp_vld_d        = 1'b0;
        bus_dout         = wdata_q;
        bus_if.req_ready = 1'b0;
        bus_if.mem_ena   = 1'b0;
        bus_if.mem_wena  = 1'b0;
`ifdef RAM2_MASTER_CLEAR_EN
        init_d           = init_q;
        clear_busy       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr_go) begin
`ifdef RAM2_MASTER_CLEAR_EN
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                    init_d  = 1'b0;
`endif
                end else begin
                    // Gated by rst_n so ready stays low for the whole reset.
                    bus_if.req_ready = rst_n;
                    if (bus_if.req_valid) begin
                        addr_d  = bus_if.req_addr;
                        wdata_d = bus_if.req_wdata;
                        state_d = bus_if.req_write ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                bus_if.mem_ena  = 1'b1;
                bus_if.mem_wena = 1'b1;
                state_d         = ST_IDLE;
            end
            ST_READ: begin
                bus_if.mem_ena = 1'b1;
                rdata_d        = bus_din;
                rsp_vld_d      = 1'b1;
                state_d        = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`ifdef RAM2_MASTER_CLEAR_EN
            ST_CLEAR: begin
                bus_if.mem_ena  = 1'b1;
                bus_if.mem_wena = 1'b1;
                bus_dout        = '0;
                clear_busy      = 1'b1;
                if (addr_q == ADDR_W'(RAM_DEPTH - 1)) state_d = ST_IDLE;
                else                                   addr_d  = addr_q + ADDR_W'(1);
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_if.mem_addr  = addr_q;
    assign bus_if.rsp_valid = rsp_vld_q;
    assign bus_if.rsp_rdata = rdata_q;

    ram2_bus_drv #(.W(DATA_W)) u_bus_drv (
        .oe   (bus_if.mem_wena),
        .dout (bus_dout),
        .bus  (mem_data_io),
        .din  (bus_din)
    );
endmodule

// File: doc/ram2_master.md
RAM2_MASTER -- requirements
Module: ram2_master

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the RAM word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, SHALL set the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL mean the client request is valid.
REQ-006 req_ready  output  1  SHALL mean the master accepts a request this cycle.
REQ-007 req_write  input  1  SHALL select write (1) or read (0).
REQ-008 req_addr  input  ADDR_W  SHALL be the target word address.
REQ-009 req_wdata  input  DATA_W  SHALL be the write data.
REQ-010 rsp_valid  output  1  SHALL be a one-cycle read-data-valid pulse; there is no backpressure.
REQ-011 rsp_rdata  output  DATA_W  SHALL be the read data, held until the next read completes.
REQ-012 mem_ena, mem_wena  output  1 each  SHALL drive the RAM enable and write-enable.
REQ-013 mem_addr  output  ADDR_W  SHALL drive the RAM address.
REQ-014 mem_data_io  inout  DATA_W  SHALL be the shared tri-state data bus, driven by the master only while mem_wena=1; otherwise it is high-Z.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITE, READ, TURN (plus CLEAR under REQ-026).
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid&req_ready=1, and all req_* fields are registered at that edge.
REQ-017 After an accepted write, the FSM SHALL go to WRITE for exactly one cycle with mem_ena=1, mem_wena=1, mem_addr and mem_data_io driven; the RAM commits at the edge that ends WRITE; the FSM then returns to IDLE.
REQ-018 After an accepted read, the FSM SHALL go to READ for one cycle with mem_ena=1, mem_wena=0 and the bus released; at the edge that ends READ, rsp_rdata SHALL capture mem_data_io and rsp_valid=1 for the following cycle; the FSM then goes to TURN.
REQ-019 TURN SHALL last one cycle with mem_ena=0, mem_wena=0 and the bus high-Z (bus turnaround), then return to IDLE; a write SHALL therefore never drive the bus in the cycle directly after a READ.
REQ-020 Throughput SHALL be one write per 2 cycles and one read per 3 cycles; back-to-back requests held on req_valid SHALL be accepted in each IDLE cycle.
REQ-021 In IDLE, mem_ena=0, mem_wena=0 and the bus SHALL be high-Z; mem_addr SHALL hold its last value.
REQ-022 Address wrap: the address SHALL be used exactly as given, with no arithmetic; 31 is a legal address.

Reset
REQ-023 While rst_n=0, the block SHALL force immediately (asynchronously): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_ena=0, mem_wena=0, mem_addr=0, bus high-Z.
REQ-024 Reset mid-WRITE or mid-READ SHALL abort the operation with no response; the RAM contents at the aborted address are undefined.
REQ-025 req_ready SHALL rise in the first cycle after rst_n deasserts (or after CLEAR completes when RAM2_MASTER_CLEAR_EN is defined).

Configuration
REQ-026 With RAM2_MASTER_CLEAR_EN defined: add inputs clear_start and output clear_busy. A clear_start pulse in IDLE, or the exit from reset, SHALL enter CLEAR, writing 0 to addresses 0..31 (one per cycle, ena=1, wena=1). clear_busy=1 and req_ready=0 throughout; the FSM returns to IDLE after address 31. clear_start outside IDLE SHALL be ignored.
REQ-027 Without the macro, the CLEAR state, clear_start and clear_busy SHALL be absent, and the RAM contents after reset SHALL be left untouched.

Structure
REQ-028 A shared package ram2_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state enum, and RAM_DEPTH=32.
REQ-029 The tri-state driver SHALL be one sub-module, ram2_bus_drv (inputs oe, dout; inout bus; output din).

Verification
REQ-030 Write addr 0 = f0ff0f0f, then read addr 0 -> rsp_valid pulses 2 cycles after the read is accepted, with rsp_rdata=f0ff0f0f.
REQ-031 Write addr 4 = ff00ff00, then immediately request a write to addr 5 = fff0fff0 -> both are accepted on consecutive IDLE cycles, and reads return ff00ff00 and fff0fff0.
REQ-032 Read addr 5 followed by a pending write -> mem_data_io is high-Z in the READ and TURN cycles, and the write is driven only after TURN; a checker flags any X on the bus.
REQ-033 Assert rst_n=0 during WRITE -> mem_ena=0 and the bus is high-Z in the same timestep; no rsp_valid.
REQ-034 With RAM2_MASTER_CLEAR_EN: preload addr 31 = deadbeef, pulse clear_start -> clear_busy is high for 32 cycles, and a read of addr 31 then returns 00000000.
